instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Write-side counterpart of the byte-addressed instruction memory. Accepts 32-bit
//  instruction words over a valid/ready stream and writes each one into the byte-wide
//  store as 4 consecutive bytes, big-endian: byte at addr = word[31:24], addr+3 = word[7:0].
//  Sits between the boot/download path and the memory's write port.
// PARAMETERS
//  ADDRESS_WIDTH  16  byte address width of the memory; all address arithmetic is mod 2**ADDRESS_WIDTH
//  DATA_WIDTH     32  instruction word width; fixed at 32 (4 bytes per word)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  start          in   1   pulse: begin a load session at base_addr (used only in IDLE)
//  base_addr      in   ADDRESS_WIDTH  first byte address; bits [1:0] forced to 00
//  in_valid       in   1   word available on in_data
//  in_data        in   DATA_WIDTH     instruction word
//  in_last        in   1   qualifies in_data as final word of the session
//  in_ready       out  1   loader accepts a word this cycle
//  mem_we         out  1   byte write enable
//  mem_addr       out  ADDRESS_WIDTH  byte write address
//  mem_wdata      out  8   byte write data
//  busy           out  1   session in progress (ACCEPT or WRITE)
//  done           out  1   one-cycle pulse after last byte of session written
//  words_written  out  ADDRESS_WIDTH  words completed this session (mod 2**ADDRESS_WIDTH)
// BEHAVIOUR
//  - FSM: IDLE -> ACCEPT -> WRITE(x4) -> ACCEPT | DONE -> IDLE.
//  - Reset: state IDLE; in_ready, mem_we, busy, done = 0; mem_addr, mem_wdata,
//    words_written, pointer, byte counter = 0. rst wins over every other input.
//  - IDLE: start=1 latches ptr = {base_addr[AW-1:2],2'b00}, clears words_written, -> ACCEPT.
//  - ACCEPT: in_ready=1 (decoded from state). Handshake = in_valid & in_ready at edge:
//    latch in_data and in_last, -> WRITE with byte counter k=0. No handshake: stay, no writes.
//  - WRITE: outputs registered; handshake in cycle h gives mem_we=1 in cycles h+1..h+4 with
//    mem_addr = ptr+k, mem_wdata = word[31-8k -: 8], k=0..3. in_ready=0 throughout.
//  - After k=3: ptr += 4, words_written += 1; -> DONE if latched last else ACCEPT.
//    in_ready or done is high in cycle h+5. Max throughput 1 word / 5 cycles.
//  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
//  - mem_we=0 in every state except WRITE; mem_addr/mem_wdata hold last value otherwise.
//  - Wrap: ptr+k and ptr+4 wrap mod 2**ADDRESS_WIDTH silently; no error flag.
//  - start while not IDLE: ignored. in_data/in_last ignored unless handshake occurs.
//  - rst mid-WRITE: next cycle IDLE, mem_we=0; bytes already written remain in memory.
// TESTING
//  1. rst held 2 cycles -> in_ready, mem_we, busy, done, words_written all 0.
//  2. start, base 0x0010, one word 0x00500093 last=1 -> writes (0x10,00),(0x11,50),
//     (0x12,00),(0x13,93) in h+1..h+4; done=1 at h+5 only; words_written=1.
//  3. base 0x0020, 3 words, in_valid held high -> in_ready high 1 of every 5 cycles;
//     12 byte writes at 0x20..0x2B in order; done once after 3rd word.
//  4. in_valid low 3 cycles in ACCEPT -> in_ready stays 1, mem_we stays 0, no state change.
//  5. base 0xFFFC, 2 words -> 1st at 0xFFFC..0xFFFF, 2nd at 0x0000..0x0003.
//  6. base 0x0013 -> first write at 0x0010; start pulse while busy ignored;
//     rst at byte k=2 -> next cycle mem_we=0, busy=0, IDLE.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Bundle of signals between the boot/download path, the loader and the memory write port.
// The master side drives the word stream and session control; the slave side is the loader.
interface instr_mem_loader_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] base_addr;
    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_last;
    logic                     in_ready;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [7:0]               mem_wdata;
    logic                     busy;
    logic                     done;
    logic [ADDRESS_WIDTH-1:0] words_written;

    modport master (
        output start, base_addr, in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, words_written
    );

    modport slave (
        input  start, base_addr, in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, words_written
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide memory write port, big-endian,
// four registered byte writes per accepted word.
module instr_mem_loader #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic               clk,
    input  logic               rst,
    instr_mem_loader_if.slave  bus
);
    localparam int AW = ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  last_q, last_d;
    logic [1:0]            k_q, k_d;
    logic [AW-1:0]         words_q, words_d;
    logic                  mem_we_q, mem_we_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;

    // Byte lanes of the latched word, lane 0 is the most significant byte.
    logic [7:0] word_bytes [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_bytes[gi] = word_q[DATA_WIDTH-1-8*gi -: 8];
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        word_d      = word_q;
        last_d      = last_q;
        k_d         = k_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ptr_d   = bus.base_addr & ~AW'(3);
                    words_d = '0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                // The first byte is staged on the handshake edge so writes start at h+1.
                if (bus.in_valid) begin
                    word_d      = bus.in_data;
                    last_d      = bus.in_last;
                    k_d         = 2'd0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = bus.in_data[DATA_WIDTH-1 -: 8];
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (k_q != 2'd3) begin
                    k_d         = k_q + 2'd1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q + AW'(k_d);
                    mem_wdata_d = word_bytes[k_d];
                end else begin
                    ptr_d   = ptr_q + AW'(4);
                    words_d = words_q + AW'(1);
                    state_d = last_q ? S_DONE : S_ACCEPT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            k_q         <= 2'd0;
            words_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            word_q      <= word_d;
            last_q      <= last_d;
            k_q         <= k_d;
            words_q     <= words_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.in_ready      = (state_q == S_ACCEPT);
    assign bus.busy          = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.words_written = words_q;
endmodule
